// File: rtl/ks_pkg.sv
// Shared definitions for the wide-add sequencer.
//   LIMB_W    : width of one limb, matching the 16-bit prefix adder
//   ks_state_t: sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   idx_width : limb index counter width, never less than 1 bit
package ks_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ks_wide_add_seq_kogge_stone.sv
// KoggeStone: 16-bit parallel-prefix adder, purely combinational.
//   A, B : addends
//   Cin  : carry-in
//   S    : sum
//   Cout : carry out of bit 15
module KoggeStone
    import ks_pkg::*;
(
    input  logic [LIMB_W-1:0] A,
    input  logic [LIMB_W-1:0] B,
    input  logic              Cin,
    output logic [LIMB_W-1:0] S,
    output logic              Cout
);
    localparam int LVLS = $clog2(LIMB_W);

    // w_g[k][i]/w_p[k][i]: group generate/propagate over bits
    // [i : i-2^k+1] (clipped at bit 0) after k prefix levels.
    logic [LVLS:0][LIMB_W-1:0] w_g;
    logic [LVLS:0][LIMB_W-1:0] w_p;
    logic [LIMB_W:0]           w_c;

    assign w_g[0] = A & B;
    assign w_p[0] = A ^ B;

    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        for (genvar i = 0; i < LIMB_W; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_merge
                assign w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-(1<<k)]);
                assign w_p[k+1][i] = w_p[k][i] & w_p[k][i-(1<<k)];
            end else begin : g_pass
                assign w_g[k+1][i] = w_g[k][i];
                assign w_p[k+1][i] = w_p[k][i];
            end
        end
    end

    // Fold Cin in after the tree: carry into bit i+1 is G[i:0] | P[i:0]&Cin.
    assign w_c[0] = Cin;
    for (genvar i = 0; i < LIMB_W; i++) begin : g_carry
        assign w_c[i+1] = w_g[LVLS][i] | (w_p[LVLS][i] & Cin);
    end

    assign S    = w_p[0] ^ w_c[LIMB_W-1:0];
    assign Cout = w_c[LIMB_W];

endmodule

// File: rtl/ks_wide_add_seq.sv
// ks_wide_add_seq: NLIMBS*16-bit add on a single shared 16-bit KoggeStone
// adder, one limb per cycle, LSB limb first, carry chained through r_carry.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   : operands and limb-0 carry-in
//   in_sub               : subtract select, only with KS_SEQ_SUB_EN defined
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   out_sum, out_cout    : result and carry out of the top limb
// Optional feature macro: KS_SEQ_SUB_EN (adds in_sub, A-B via ~B + 1).
module ks_wide_add_seq
    import ks_pkg::*;
#(
    parameter int NLIMBS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLIMBS*LIMB_W-1:0] in_a,
    input  logic [NLIMBS*LIMB_W-1:0] in_b,
    input  logic                     in_cin,
`ifdef KS_SEQ_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLIMBS*LIMB_W-1:0] out_sum,
    output logic                     out_cout
);
    localparam int W     = NLIMBS * LIMB_W;
    localparam int IDX_W = idx_width(NLIMBS);

    ks_state_t         r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_a, r_b, r_sum;
    logic              r_carry, r_cout;
    logic              w_last;
    logic [LIMB_W-1:0] w_a_limb, w_b_raw, w_b_limb, w_s;
    logic              w_cout;

    assign w_last   = (r_idx == IDX_W'(NLIMBS - 1));
    assign w_a_limb = r_a[r_idx*LIMB_W +: LIMB_W];
    assign w_b_raw  = r_b[r_idx*LIMB_W +: LIMB_W];

`ifdef KS_SEQ_SUB_EN
    logic r_sub;
    // Subtract as A + ~B + 1; the +1 enters via the limb-0 carry at capture.
    assign w_b_limb = r_sub ? ~w_b_raw : w_b_raw;
`else
    assign w_b_limb = w_b_raw;
`endif

    KoggeStone u_ks (
        .A    (w_a_limb),
        .B    (w_b_limb),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef KS_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_idx <= '0;
`ifdef KS_SEQ_SUB_EN
                        r_sub   <= in_sub;
                        r_carry <= in_sub | in_cin;
`else
                        r_carry <= in_cin;
`endif
                    end
                end
                RUN: begin
                    r_sum[r_idx*LIMB_W +: LIMB_W] <= w_s;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;

endmodule

// File: tb/tb_ks_wide_add_seq.sv
module tb_ks_wide_add_seq;
    localparam int NL = 4;
    localparam int W  = NL * 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout;
`ifdef KS_SEQ_SUB_EN
    logic         in_sub;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ks_wide_add_seq #(.NLIMBS(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef KS_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and hold until the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        chk("issue_ready", W'(in_ready), W'(1));
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
`ifdef KS_SEQ_SUB_EN
        in_sub = sub;
`else
        if (sub) $display("note: subtract requested without KS_SEQ_SUB_EN");
`endif
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] exp_s, input logic exp_c);
        int lat;
        issue(a, b, cin, sub);
        wait_valid(lat);
        chk({tag, "_lat"}, W'(lat), W'(NL));
        chk({tag, "_sum"}, out_sum, exp_s);
        chk({tag, "_cout"}, W'(out_cout), W'(exp_c));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
`ifdef KS_SEQ_SUB_EN
        in_sub = 1'b0;
`endif
        #12;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_sum", out_sum, W'(0));
        chk("rst_out_cout", W'(out_cout), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("t1", 64'h1111_1111_1111_1111, 64'hABCD_ABCD_ABCD_ABCD, 1'b0, 1'b0,
               64'hBCDE_BCDE_BCDE_BCDE, 1'b0);
        run_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
        run_op("t3", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);

        // Backpressure in DONE with a new request held pending.
        issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        wait_valid(lat);
        chk("t4_lat", W'(lat), W'(NL));
        in_a = 64'h8000_0000_0000_0000; in_b = 64'h8000_0000_0000_0001;
        in_cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", W'(out_valid), W'(1));
            chk("t4_hold_sum", out_sum, 64'h1234_5678_9ABC_DF00);
            chk("t4_hold_cout", W'(out_cout), W'(0));
            chk("t4_hold_ready", W'(in_ready), W'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_idle_valid", W'(out_valid), W'(0));
        chk("t4_idle_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        chk("t4_accepted", W'(in_ready), W'(0));
        wait_valid(lat);
        chk("t4_pend_lat", W'(lat), W'(NL));
        chk("t4_pend_sum", out_sum, 64'h2);
        chk("t4_pend_cout", W'(out_cout), W'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in RUN at idx=2: limbs 0,1 are already partially summed.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", W'(out_valid), W'(0));
        chk("t5_rst_sum", out_sum, W'(0));
        chk("t5_rst_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("t5_next", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0);

`ifdef KS_SEQ_SUB_EN
        run_op("t6a", 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("t6b", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
